pong_round_controller: RTL and testbench

- Game-flow sequencer for the pong datapath; sits between the VGA timing generator, the ball-physics processor wrapper and the 7-segment decoder.
- Runs on the pixel clock and advances on frame ticks. It holds the ball at its initial position for a serve countdown, then releases it.
- It detects goals reported by the processor, keeps both scores, freezes play briefly after each point and declares game over at a target score.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_round_controller_edge.sv | 27 ++
 rtl/pong_round_controller.sv | 197 +++++++++++++++++++
 tb/tb_pong_round_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong round controller.
// Holds the FSM encoding, the goal codes and the score helper.
package pong_pkg;

    localparam int SCORE_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [2:0] WIN_NONE = 3'd0;
    localparam logic [2:0] WIN_P1   = 3'd1;
    localparam logic [2:0] WIN_P2   = 3'd2;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;
    localparam logic [3:0] DIGIT_TOP = 4'd3;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s
    );
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_round_controller_edge.sv
// Rising-edge detector: one-cycle pulse per low-to-high input transition.
// Used for frame_tick and start_btn qualification.
module pulse_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/pong_round_controller.sv
// Game-flow sequencer: serve countdown, play, point freeze, game over.
// Advances on qualified frame ticks; every output is a flop.
module pong_round_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [2:0] winner,
    output logic       ball_reset,
    output logic       ball_run,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] countdown,
    output logic       game_over,
    output logic [1:0] champion,
    output logic       flash,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_THR  = SCORE_W'(WIN_SCORE);

    logic tick;
    logic start;
    logic goal;

    logic [2:0]         state_q,      state_d;
    logic [3:0]         digit_q,      digit_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [2:0]         fcnt_q,       fcnt_d;
    logic [SCORE_W-1:0] p1_q,         p1_d;
    logic [SCORE_W-1:0] p2_q,         p2_d;
    logic [1:0]         champ_q,      champ_d;
    logic               flash_q,      flash_d;
    logic [2:0]         win_prev_q,   win_prev_d;
    logic               ball_reset_q, ball_reset_d;
    logic               ball_run_q,   ball_run_d;
    logic [3:0]         countdown_q,  countdown_d;
    logic               game_over_q,  game_over_d;

    pulse_edge_detect u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .in    (frame_tick),
        .pulse (tick)
    );

    pulse_edge_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .in    (start_btn),
        .pulse (start)
    );

    // Only a fresh 0 -> P1/P2 transition counts; held or odd codes do not.
    assign goal = (state_q == ST_PLAY)
               && (win_prev_q == WIN_NONE)
               && ((winner == WIN_P1) || (winner == WIN_P2));

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        champ_d    = champ_q;
        flash_d    = flash_q;
        win_prev_d = winner;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    champ_d = 2'd0;
                    digit_d = DIGIT_TOP;
                    cnt_d   = '0;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d = '0;
                        if (digit_q == 4'd1) begin
                            digit_d = 4'd0;
                            state_d = ST_PLAY;
                        end else begin
                            digit_d = digit_q - 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // A tick coinciding with the goal is dropped on purpose.
                if (goal) begin
                    if (winner == WIN_P1) begin
                        p1_d = sat_inc(p1_q);
                    end else begin
                        p2_d = sat_inc(p2_q);
                    end
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    flash_d = 1'b1;
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (tick) begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (fcnt_q == 3'd7) begin
                        flash_d = ~flash_q;
                    end
                    if (cnt_q == POINT_LAST) begin
                        cnt_d   = '0;
                        flash_d = 1'b0;
                        if ((p1_q >= WIN_THR) || (p2_q >= WIN_THR)) begin
                            champ_d = (p1_q > p2_q) ? 2'd1 : 2'd2;
                            state_d = ST_OVER;
                        end else begin
                            digit_d = DIGIT_TOP;
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ball_reset_d = (state_d == ST_IDLE)
                    || (state_d == ST_SERVE)
                    || (state_d == ST_OVER);
        ball_run_d   = (state_d == ST_PLAY);
        countdown_d  = (state_d == ST_SERVE) ? digit_d : 4'd0;
        game_over_d  = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            digit_q      <= 4'd0;
            cnt_q        <= '0;
            fcnt_q       <= 3'd0;
            p1_q         <= '0;
            p2_q         <= '0;
            champ_q      <= 2'd0;
            flash_q      <= 1'b0;
            win_prev_q   <= WIN_NONE;
            ball_reset_q <= 1'b1;
            ball_run_q   <= 1'b0;
            countdown_q  <= 4'd0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            champ_q      <= champ_d;
            flash_q      <= flash_d;
            win_prev_q   <= win_prev_d;
            ball_reset_q <= ball_reset_d;
            ball_run_q   <= ball_run_d;
            countdown_q  <= countdown_d;
            game_over_q  <= game_over_d;
        end
    end

    assign state      = state_q;
    assign p1_score   = p1_q;
    assign p2_score   = p2_q;
    assign champion   = champ_q;
    assign flash      = flash_q;
    assign ball_reset = ball_reset_q;
    assign ball_run   = ball_run_q;
    assign countdown  = countdown_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_round_controller.sv
// Scoreboard bench for pong_round_controller with a short game setup.
// Expected output snapshots are queued before each stimulus and checked after.
module tb_pong_round_controller;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] cd;
        logic       br;
        logic       run;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       go;
        logic [1:0] ch;
        logic       fl;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic [2:0] winner = 3'd0;
    logic       ball_reset;
    logic       ball_run;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] countdown;
    logic       game_over;
    logic [1:0] champion;
    logic       flash;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    snap_t exp_q[$];
    string tag_q[$];

    pong_round_controller #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (3),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .winner     (winner),
        .ball_reset (ball_reset),
        .ball_run   (ball_run),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .countdown  (countdown),
        .game_over  (game_over),
        .champion   (champion),
        .flash      (flash),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic snap_t mk(input logic [2:0] st, input logic [3:0] cd,
                                 input logic br, input logic run,
                                 input logic [3:0] p1, input logic [3:0] p2,
                                 input logic go, input logic [1:0] ch,
                                 input logic fl);
        snap_t s;
        s.st = st; s.cd = cd; s.br = br; s.run = run;
        s.p1 = p1; s.p2 = p2; s.go = go; s.ch = ch; s.fl = fl;
        return s;
    endfunction

    task automatic sb_push(input string tag, input snap_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        snap_t e;
        string t;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".state"},      32'(state),      32'(e.st));
        chk({t, ".countdown"},  32'(countdown),  32'(e.cd));
        chk({t, ".ball_reset"}, 32'(ball_reset), 32'(e.br));
        chk({t, ".ball_run"},   32'(ball_run),   32'(e.run));
        chk({t, ".p1_score"},   32'(p1_score),   32'(e.p1));
        chk({t, ".p2_score"},   32'(p2_score),   32'(e.p2));
        chk({t, ".game_over"},  32'(game_over),  32'(e.go));
        chk({t, ".champion"},   32'(champion),   32'(e.ch));
        chk({t, ".flash"},      32'(flash),      32'(e.fl));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic press();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
    endtask

    task automatic serve_out(input logic [3:0] p1, input logic [3:0] p2);
        repeat (6) tick();
        sb_push("to_play", mk(3'd2, 4'd0, 1'b0, 1'b1, p1, p2, 1'b0, 2'd0, 1'b0));
        sb_check();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        reset = 1'b0;
        #1;
        sb_push("reset", mk(3'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        step();
        reset = 1'b1;
        step();

        // Serve countdown with a long tick level counting once.
        sb_push("start", mk(3'd1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        start_btn = 1'b1;
        step();
        sb_check();
        start_btn = 1'b0;
        step();
        frame_tick = 1'b1;
        repeat (5) step();
        frame_tick = 1'b0;
        step();
        sb_push("held_tick", mk(3'd1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        tick();
        sb_push("cd2", mk(3'd1, 4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        tick();
        tick();
        sb_push("cd1", mk(3'd1, 4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        tick();
        sb_push("cd1_mid", mk(3'd1, 4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        tick();
        sb_push("play", mk(3'd2, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();

        // P1 goal held for 100 cycles scores once.
        winner = 3'd1;
        sb_push("p1_goal", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0, 1'b1));
        step();
        sb_check();
        repeat (99) step();
        sb_push("p1_held", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0, 1'b1));
        sb_check();
        winner = 3'd0;
        step();
        tick();
        tick();
        press();
        sb_push("pt_start", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0, 1'b1));
        sb_check();
        tick();
        sb_push("pt_exit", mk(3'd1, 4'd3, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        serve_out(4'd1, 4'd0);
        press();
        sb_push("play_start", mk(3'd2, 4'd0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();

        // Goal and tick together: the tick must not count.
        winner = 3'd2;
        frame_tick = 1'b1;
        sb_push("goal_tick", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 2'd0, 1'b1));
        step();
        sb_check();
        frame_tick = 1'b0;
        step();
        tick();
        tick();
        sb_push("gt_two", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 2'd0, 1'b1));
        sb_check();
        tick();
        sb_push("gt_exit", mk(3'd1, 4'd3, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 2'd0, 1'b0));
        sb_check();
        serve_out(4'd1, 4'd1);

        // Asynchronous reset in the middle of a cycle.
        winner = 3'd0;
        step();
        #2;
        reset = 1'b0;
        #1;
        sb_push("async_rst", mk(3'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();
        #1;
        reset = 1'b1;
        step();

        press();
        serve_out(4'd0, 4'd0);
        winner = 3'd3;
        step();
        winner = 3'd0;
        step();
        sb_push("code3", mk(3'd2, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();

        // P2 wins two points.
        winner = 3'd2;
        sb_push("p2_g1", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 2'd0, 1'b1));
        step();
        sb_check();
        winner = 3'd0;
        repeat (3) tick();
        sb_push("p2_g1x", mk(3'd1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 2'd0, 1'b0));
        sb_check();
        serve_out(4'd0, 4'd1);
        winner = 3'd2;
        sb_push("p2_g2", mk(3'd3, 4'd0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 2'd0, 1'b1));
        step();
        sb_check();
        winner = 3'd0;
        repeat (3) tick();
        sb_push("over", mk(3'd4, 4'd0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 2'd2, 1'b0));
        sb_check();
        tick();
        sb_push("over_hold", mk(3'd4, 4'd0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 2'd2, 1'b0));
        sb_check();
        press();
        sb_push("restart", mk(3'd1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0));
        sb_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
